// File: rtl/keymap_swap_ctrl_pkg.sv
// rtl/keymap_swap_ctrl_pkg.sv - key width, state encoding and one-hot helper for the keymap swap controller
`ifndef NOTE_KEY_BITS
`define NOTE_KEY_BITS 7
`endif

package keymap_swap_ctrl_pkg;

  localparam int KEY_W = `NOTE_KEY_BITS;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [3:0]       state_t;

  localparam state_t IDLE      = 4'd0;
  localparam state_t S_SRC     = 4'd1;
  localparam state_t S_SRC_REL = 4'd2;
  localparam state_t S_DST     = 4'd3;
  localparam state_t S_RD_A    = 4'd4;
  localparam state_t S_RD_B    = 4'd5;
  localparam state_t S_WR_A    = 4'd6;
  localparam state_t S_WR_B    = 4'd7;
  localparam state_t S_DST_REL = 4'd8;

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  function automatic logic is_onehot(input key_t v);
    return (v != '0) && ((v & (v - key_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/keymap_swap_ctrl_if.sv
// rtl/keymap_swap_ctrl_if.sv - remap RAM port between the swap controller (master) and the RAM (slave)
interface keymap_swap_ctrl_if;
  import keymap_swap_ctrl_pkg::*;

  logic ram_rw;
  key_t ram_addr;
  key_t ram_wdata;
  key_t ram_rdata;

  modport master (output ram_rw, output ram_addr, output ram_wdata, input ram_rdata);
  modport slave  (input ram_rw, input ram_addr, input ram_wdata, output ram_rdata);

endinterface

// File: rtl/keymap_swap_ctrl.sv
// rtl/keymap_swap_ctrl.sv - note-key remap sequencer: play lookup and config-mode two-key swap (optional wait timeout: KEYMAP_TIMEOUT_EN)
module keymap_swap_ctrl
  import keymap_swap_ctrl_pkg::*;
`ifdef KEYMAP_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 100_000_000)
`endif
  (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_en,
  input  key_t                       key_in,
  keymap_swap_ctrl_if.master         ram,
  output key_t                       note_out,
  output logic                       busy,
  output logic                       swap_done,
  output logic                       cfg_timeout
);

  state_t state;
  state_t state_next;
  key_t   src;
  key_t   dst;
  key_t   map_a;
  key_t   map_b;
  logic   key_valid;
  logic   timeout_hit;
  logic   timeout_fire;

  assign key_valid = is_onehot(key_in);

`ifdef KEYMAP_TIMEOUT_EN
  logic [26:0] wait_cnt;
  logic        waiting;

  assign waiting     = (state == S_SRC_REL) || (state == S_DST) || (state == S_DST_REL);
  assign timeout_hit = waiting && (wait_cnt == 27'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      cfg_timeout <= 1'b0;
    end else begin
      wait_cnt    <= (state_next != state || !waiting) ? '0 : wait_cnt + 27'd1;
      cfg_timeout <= timeout_fire;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign cfg_timeout = 1'b0;
`endif

  // A dropped cfg_en outranks the timeout; the timeout only matters while still configuring.
  assign timeout_fire = timeout_hit && cfg_en;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Leaving config mode aborts everywhere except S_WR_A, so a swap is never left half-written.
  always_comb begin
    state_next = state;
    if (!cfg_en && state != S_WR_A) begin
      state_next = IDLE;
    end else if (timeout_fire) begin
      state_next = S_SRC;
    end else begin
      case (state)
        IDLE:      if (cfg_en)         state_next = S_SRC;
        S_SRC:     if (key_valid)      state_next = S_SRC_REL;
        S_SRC_REL: if (key_in == '0)   state_next = S_DST;
        S_DST:     if (key_valid)      state_next = (key_in == src) ? S_DST_REL : S_RD_A;
        S_RD_A:                        state_next = S_RD_B;
        S_RD_B:                        state_next = S_WR_A;
        S_WR_A:                        state_next = S_WR_B;
        S_WR_B:                        state_next = S_DST_REL;
        S_DST_REL: if (key_in == '0)   state_next = S_SRC;
        default:                       state_next = IDLE;
      endcase
    end
  end

  // RAM port is forced quiet while rst is held so a reset mid-swap cannot write.
  always_comb begin
    ram.ram_rw    = 1'b0;
    ram.ram_addr  = '0;
    ram.ram_wdata = '0;
    if (!rst) begin
      case (state)
        IDLE:   ram.ram_addr = key_in;
        S_RD_A: ram.ram_addr = src;
        S_RD_B: ram.ram_addr = dst;
        S_WR_A: begin
          ram.ram_rw    = 1'b1;
          ram.ram_addr  = src;
          ram.ram_wdata = map_b;
        end
        S_WR_B: begin
          ram.ram_rw    = 1'b1;
          ram.ram_addr  = dst;
          ram.ram_wdata = map_a;
        end
        default: ram.ram_addr = '0;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      map_a     <= '0;
      map_b     <= '0;
      note_out  <= '0;
      swap_done <= 1'b0;
    end else begin
      note_out  <= (state == IDLE && !cfg_en && key_valid) ? ram.ram_rdata : '0;
      swap_done <= (state == S_WR_B);
      if (state == S_RD_A) map_a <= ram.ram_rdata;
      if (state == S_RD_B) map_b <= ram.ram_rdata;
      if (timeout_fire) begin
        src <= '0;
        dst <= '0;
      end else begin
        if (state == S_SRC && state_next == S_SRC_REL) src <= key_in;
        if (state == S_DST && state_next == S_RD_A)    dst <= key_in;
      end
    end
  end

endmodule

// File: tb/tb_keymap_swap_ctrl.sv
// tb/tb_keymap_swap_ctrl.sv - self-checking bench with remap RAM and permutation reference model
module tb_keymap_swap_ctrl;
  import keymap_swap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic cfg_en;
  key_t key_in;
  key_t note_out;
  logic busy;
  logic swap_done;
  logic cfg_timeout;

  keymap_swap_ctrl_if ram_if ();

  key_t mem [KEY_W];
  logic ram_init;
  int   wr_cnt;

  int perm [KEY_W];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef KEYMAP_TIMEOUT_EN
  keymap_swap_ctrl #(.TIMEOUT_CYCLES(16)) dut (
`else
  keymap_swap_ctrl dut (
`endif
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .key_in(key_in), .ram(ram_if),
    .note_out(note_out), .busy(busy), .swap_done(swap_done), .cfg_timeout(cfg_timeout)
  );

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < KEY_W; i++) mem[i] <= key_t'(1) << i;
      wr_cnt <= 0;
    end else if (ram_if.ram_rw) begin
      for (int i = 0; i < KEY_W; i++) if (ram_if.ram_addr[i]) mem[i] <= ram_if.ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always_comb begin
    ram_if.ram_rdata = '0;
    for (int i = 0; i < KEY_W; i++) if (ram_if.ram_addr[i]) ram_if.ram_rdata = ram_if.ram_rdata | mem[i];
  end

  function automatic key_t oh(input int i);
    return key_t'(1) << i;
  endfunction

  function automatic key_t model_note(input key_t k);
    int n = 0;
    int idx = 0;
    for (int i = 0; i < KEY_W; i++) if (k[i]) begin n++; idx = i; end
    return (n == 1) ? oh(perm[idx]) : '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play(input key_t k);
    key_in = k;
    tick();
    check("play_note", note_out, model_note(k));
  endtask

  // From IDLE: enter config, press and release the source key; ends in the destination wait.
  task automatic enter_dst(input int s);
    cfg_en = 1'b1;
    key_in = '0;
    tick();
    check("cfg_busy", busy, 1);
    check("cfg_note", note_out, 0);
    key_in = oh(s);
    tick();
    key_in = '0;
    tick();
    check("dst_wait_rw", ram_if.ram_rw, 0);
  endtask

  task automatic run_swap(input int s, input int d);
    int w0;
    int t;
    w0 = wr_cnt;
    key_in = oh(d);
    tick();
    check("rd_a_addr", ram_if.ram_addr, oh(s));
    check("rd_a_rw", ram_if.ram_rw, 0);
    tick();
    check("rd_b_addr", ram_if.ram_addr, oh(d));
    tick();
    check("wr_a_rw", ram_if.ram_rw, 1);
    check("wr_a_addr", ram_if.ram_addr, oh(s));
    check("wr_a_data", ram_if.ram_wdata, oh(perm[d]));
    tick();
    check("wr_b_rw", ram_if.ram_rw, 1);
    check("wr_b_addr", ram_if.ram_addr, oh(d));
    check("wr_b_data", ram_if.ram_wdata, oh(perm[s]));
    tick();
    check("swap_done", swap_done, 1);
    check("swap_writes", wr_cnt - w0, 2);
    t = perm[s]; perm[s] = perm[d]; perm[d] = t;
    check("mem_src", mem[s], oh(perm[s]));
    check("mem_dst", mem[d], oh(perm[d]));
    tick();
    check("swap_done_pulse", swap_done, 0);
  endtask

  task automatic run_cancel(input int s);
    int w0;
    w0 = wr_cnt;
    key_in = oh(s);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cancel_rw", ram_if.ram_rw, 0);
      check("cancel_done", swap_done, 0);
    end
    check("cancel_writes", wr_cnt - w0, 0);
  endtask

  task automatic leave_cfg();
    key_in = '0;
    tick();
    cfg_en = 1'b0;
    tick();
    check("leave_busy", busy, 0);
  endtask

  initial begin
    int s;
    int d;
    int w0;
    int t;
    rst = 1'b1; cfg_en = 1'b0; key_in = '0; ram_init = 1'b1;
    for (int i = 0; i < KEY_W; i++) perm[i] = i;
    tick();
    tick();
    rst = 1'b0; ram_init = 1'b0;
    check("rst_note", note_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rw", ram_if.ram_rw, 0);
    check("rst_addr", ram_if.ram_addr, 0);
    check("rst_wdata", ram_if.ram_wdata, 0);
    check("rst_done", swap_done, 0);
    check("rst_tmo", cfg_timeout, 0);

    play(7'b0000100);
    check("play_exact", note_out, 7'b0000100);
    play(7'b0000101);
    check("play_multi", note_out, 0);
    play(7'b0000000);

    enter_dst(0);
    run_swap(0, 2);
    leave_cfg();
    play(7'b0000001);
    check("swapped_note", note_out, 7'b0000100);

    enter_dst(3);
    run_cancel(3);
    leave_cfg();
    play(7'b0001000);

    // Drop cfg_en while in S_WR_A: second write must still happen.
    enter_dst(4);
    w0 = wr_cnt;
    key_in = oh(6);
    tick(); tick(); tick();
    check("abort_wra_rw", ram_if.ram_rw, 1);
    cfg_en = 1'b0;
    tick();
    check("abort_wrb_rw", ram_if.ram_rw, 1);
    check("abort_wrb_addr", ram_if.ram_addr, oh(6));
    check("abort_wrb_data", ram_if.ram_wdata, oh(perm[4]));
    tick();
    check("abort_wra_idle", busy, 0);
    check("abort_wra_done", swap_done, 1);
    check("abort_wra_writes", wr_cnt - w0, 2);
    t = perm[4]; perm[4] = perm[6]; perm[6] = t;
    key_in = '0;
    play(oh(4));
    play(oh(6));

    // Drop cfg_en while in S_RD_B: nothing written.
    enter_dst(2);
    w0 = wr_cnt;
    key_in = oh(0);
    tick(); tick();
    cfg_en = 1'b0;
    tick();
    check("abort_rdb_idle", busy, 0);
    check("abort_rdb_rw", ram_if.ram_rw, 0);
    key_in = '0;
    tick(); tick();
    check("abort_rdb_writes", wr_cnt - w0, 0);
    check("abort_rdb_done", swap_done, 0);
    play(oh(2));
    play(oh(0));

    // Reset in S_RD_A with the destination key still held.
    enter_dst(1);
    w0 = wr_cnt;
    key_in = oh(5);
    tick();
    check("rd_a_before_rst", ram_if.ram_addr, oh(1));
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_note", note_out, 0);
    check("midrst_rw", ram_if.ram_rw, 0);
    check("midrst_addr", ram_if.ram_addr, 0);
    check("midrst_wdata", ram_if.ram_wdata, 0);
    check("midrst_done", swap_done, 0);
    rst = 1'b0; cfg_en = 1'b0; key_in = '0;
    tick();
    check("midrst_writes", wr_cnt - w0, 0);
    play(oh(1));
    play(oh(5));

`ifdef KEYMAP_TIMEOUT_EN
    enter_dst(5);
    w0 = wr_cnt;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("tmo_early", cfg_timeout, 0);
    end
    tick();
    check("tmo_pulse", cfg_timeout, 1);
    check("tmo_busy", busy, 1);
    tick();
    check("tmo_pulse_end", cfg_timeout, 0);
    check("tmo_writes", wr_cnt - w0, 0);
    leave_cfg();
`else
    enter_dst(5);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("notmo_busy", busy, 1);
      check("notmo_flag", cfg_timeout, 0);
    end
    leave_cfg();
`endif

    for (int n = 0; n < 25; n++) begin
      s = int'($urandom_range(0, KEY_W - 1));
      d = int'($urandom_range(0, KEY_W - 1));
      enter_dst(s);
      if (s == d) run_cancel(s);
      else        run_swap(s, d);
      leave_cfg();
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 3) == 0) play(key_t'($urandom));
        else                           play(oh(int'($urandom_range(0, KEY_W - 1))));
      end
    end
    for (int i = 0; i < KEY_W; i++) play(oh(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
